input_skew_b: RTL and testbench
===============================

Name: input_skew_b

Overview:
- Downstream neighbour of the B-operand input buffer. It sits between that buffer's per-column stream output and the top edge of the systolic array.
- Takes one row of COLS B-words per beat and applies the diagonal skew the array needs: column j is delayed j cycles relative to column 0.
- Frames each tile of K_DEPTH rows, then drains the skew pipeline with zero bubbles.
- Pulses tile_done once the last word has left column COLS-1.

Parameters:
- COLS, 4, number of array columns / B lanes.
- DATA_WIDTH, 16, width of one B element.
- K_DEPTH, 64, nominal rows per tile (reduction length).

Ports:
- clk  input  1  single clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream row valid.
- in_ready  output  1  block accepts a row this cycle.
- in_data  input  COLS*DATA_WIDTH  lane j at bits [j*DATA_WIDTH +: DATA_WIDTH].
- in_last  input  1  marks the final row of a tile; qualified by in_valid && in_ready.
- array_stall  input  1  array freeze; while high the skew pipeline holds.
- out_data  output  COLS*DATA_WIDTH  skewed lane data to array top edge.
- out_valid  output  COLS  per-lane valid.
- busy  output  1  high in STREAM or DRAIN.
- tile_done  output  1  one-cycle pulse at end of drain.
- len_err  output  1  one-cycle pulse on tile-length violation.

Behaviour:
- Reset (async on rst high): all outputs 0, state IDLE, all pipeline stages cleared, counters 0.
  - Mid-tile reset discards all in-flight data; no tile_done is produced.
- Definitions:
  - adv = !array_stall.
  - accept = in_valid && in_ready.
  - in_ready = adv && (state != DRAIN). Combinational; no dependency on in_valid.
- Lane j holds a register chain of depth j+1.
  - Lane output latency is 1+j advancing cycles from accept.
  - All chains shift only when adv=1; when adv=0 every stage holds and out_data/out_valid are frozen.
- On an advancing cycle without accept, a bubble enters every lane head: data 0, valid 0.
- out_data lanes are forced to 0 whenever the corresponding out_valid bit is 0.
- row_cnt is $clog2(K_DEPTH+1) bits wide.
  - Cleared on entry to STREAM.
  - Increments on each accept.
- State machine:
  - IDLE: first accept moves to STREAM; row_cnt becomes 1. If that row also has in_last (K_DEPTH≥2), go directly to DRAIN.
  - STREAM: on accept with in_last, or when row_cnt reaches K_DEPTH, go to DRAIN.
  - DRAIN: drain_cnt counts COLS advancing cycles. When it reaches COLS, pulse tile_done and return to IDLE. Input is blocked throughout.
- len_err pulses in the cycle DRAIN is entered if either:
  - in_last arrived with row_cnt != K_DEPTH, or
  - row_cnt hit K_DEPTH without in_last.
  - The tile is still drained normally in both cases.
- Back-to-back tiles: the new tile's first row may be accepted in the cycle after tile_done.
- Stall during DRAIN freezes drain_cnt. tile_done never fires during a stall.
- busy = (state != IDLE).

Optional Feature:
- Macro INPUT_SKEW_B_STALL_CNT_EN.
- Defined:
  - Adds output port stall_cycles, 32 bits.
  - Counts cycles with array_stall=1 && busy=1; saturates at all-ones.
  - Cleared on IDLE->STREAM; holds its value after tile_done until the next tile starts.
  - Reset value 0.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Skew check: COLS=4, K_DEPTH=4, rows R0..R3 with lane j = 16'h0R0j, in_valid continuous, in_last on R3.
  - Lane0 shows R0..R3 on cycles 1-4; lane3 shows R0..R3 on cycles 4-7.
  - tile_done pulses on cycle 8; len_err stays 0.
- Stall freeze: same tile, array_stall high for 3 cycles starting cycle 2.
  - in_ready=0 and out_data/out_valid held for those cycles.
  - Sequence resumes intact; tile_done is delayed by exactly 3 cycles.
- Bubbles: in_valid low between R1 and R2 for 2 cycles.
  - Each lane shows 2 zero/invalid beats between R1 and R2 at its skewed time.
- Length errors:
  - in_last on row 2 with K_DEPTH=4: len_err pulses once, drain of 4 cycles, then tile_done.
  - No in_last after 4 rows: len_err pulses and in_ready drops after row 4.
- Reset mid-tile: rst after R1 accepted.
  - All out_valid=0 and busy=0 immediately (async); no tile_done.
  - Next tile processes normally.
- INPUT_SKEW_B_STALL_CNT_EN: 5 stall cycles in tile 1 -> stall_cycles=5 after tile_done; it clears to 0 when tile 2 starts.

Source files
------------

// File: rtl/input_skew_b.sv
// -----------------------------------------------------------------------------
// input_skew_b
//
// Purpose:
//   Sits between the B-operand input buffer and the top edge of the systolic
//   array. Each accepted row of COLS words is skewed diagonally: lane j is
//   delayed j extra advancing cycles relative to lane 0, so lane j appears
//   1+j advancing cycles after the row is accepted. Rows are framed into
//   tiles of up to K_DEPTH rows. After the last row the skew pipeline is
//   drained for COLS advancing cycles, then tile_done pulses on the next
//   advancing cycle.
//
// Optional feature (macro INPUT_SKEW_B_STALL_CNT_EN):
//   Adds the 32-bit output stall_cycles. It counts cycles in which
//   array_stall=1 while busy=1, and saturates at all-ones. It clears when a
//   new tile starts and holds its value after tile_done. When the macro is
//   undefined, the port and counter are absent.
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-high reset
//   in_valid     in   upstream row valid
//   in_ready     out  row accepted this cycle when in_valid is also high
//   in_data      in   COLS lanes; lane j at [j*DATA_WIDTH +: DATA_WIDTH]
//   in_last      in   final row of the tile (qualified by accept)
//   array_stall  in   freezes the skew pipeline and the drain counter
//   out_data     out  skewed lane data; a lane is zero when it is not valid
//   out_valid    out  per-lane valid
//   busy         out  tile in progress (STREAM or DRAIN)
//   tile_done    out  one-cycle pulse when the drain completes
//   len_err      out  one-cycle pulse on entering DRAIN with a bad tile length
//   stall_cycles out  (optional) stall cycle counter
// -----------------------------------------------------------------------------
module input_skew_b #(
    parameter int COLS       = 4,
    parameter int DATA_WIDTH = 16,
    parameter int K_DEPTH    = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [COLS*DATA_WIDTH-1:0] in_data,
    input  logic                       in_last,
    input  logic                       array_stall,
    output logic [COLS*DATA_WIDTH-1:0] out_data,
    output logic [COLS-1:0]            out_valid,
    output logic                       busy,
    output logic                       tile_done,
    output logic                       len_err
`ifdef INPUT_SKEW_B_STALL_CNT_EN
    ,
    output logic [31:0]                stall_cycles
`endif
);

    localparam int RCW = $clog2(K_DEPTH + 1);
    localparam int DCW = $clog2(COLS + 1);
    localparam logic [RCW-1:0] K_LAST    = RCW'(K_DEPTH);
    localparam logic [DCW-1:0] DRAIN_END = DCW'(COLS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [RCW-1:0] row_cnt_q, row_cnt_d;
    logic [DCW-1:0] drain_cnt_q, drain_cnt_d;
    logic           len_err_q, len_err_d;

    logic           adv;
    logic           accept;
    logic [RCW-1:0] row_cnt_new;
    logic           row_hit_k;
    logic           tile_end;

    assign adv    = !array_stall;
    assign accept = in_valid && in_ready;

    // Count including the row that is being accepted now. The first row of
    // a tile always restarts the count at 1.
    assign row_cnt_new = (state_q == IDLE) ? RCW'(1) : row_cnt_q + RCW'(1);
    assign row_hit_k   = (row_cnt_new == K_LAST);
    assign tile_end    = in_last || row_hit_k;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and tile counters
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        row_cnt_d   = row_cnt_q;
        drain_cnt_d = drain_cnt_q;
        len_err_d   = 1'b0;
        case (state_q)
            IDLE, STREAM: begin
                if (accept) begin
                    row_cnt_d = row_cnt_new;
                    state_d   = tile_end ? DRAIN : STREAM;
                    // A tile may end early (in_last before K_DEPTH rows) or
                    // without in_last (K_DEPTH rows reached). Either case is
                    // a length error, but the tile still drains normally.
                    len_err_d = tile_end && (in_last != row_hit_k);
                end
            end
            DRAIN: begin
                if (adv) begin
                    if (drain_cnt_q == DRAIN_END) begin
                        state_d     = IDLE;
                        drain_cnt_d = '0;
                    end else begin
                        drain_cnt_d = drain_cnt_q + DCW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_cnt_q   <= '0;
            drain_cnt_q <= '0;
            len_err_q   <= 1'b0;
        end else begin
            row_cnt_q   <= row_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            len_err_q   <= len_err_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        // Gating in_ready with rst keeps every output low during reset.
        in_ready  = !rst && adv && (state_q != DRAIN);
        busy      = (state_q != IDLE);
        // The pulse fires only on an advancing cycle, so a stall defers it.
        tile_done = (state_q == DRAIN) && (drain_cnt_q == DRAIN_END) && adv;
        len_err   = len_err_q;
    end

    // ------------------------------------------------------------------
    // Skew pipeline: lane gi is a chain of gi+1 stages. Stage 0 is in the
    // LSBs. Every chain shifts together on adv. A bubble (data 0, valid 0)
    // enters the head of each chain on an advancing cycle without accept.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < COLS; gi++) begin : g_lane
        localparam int DEPTH = gi + 1;

        logic [DEPTH*DATA_WIDTH-1:0] dat_q, dat_d;
        logic [DEPTH-1:0]            vld_q, vld_d;
        logic [DATA_WIDTH-1:0]       head_dat;

        assign head_dat = accept ? in_data[gi*DATA_WIDTH +: DATA_WIDTH] : '0;

        if (gi == 0) begin : g_head
            always_comb begin
                dat_d = dat_q;
                vld_d = vld_q;
                if (adv) begin
                    dat_d = head_dat;
                    vld_d = accept;
                end
            end
        end else begin : g_chain
            always_comb begin
                dat_d = dat_q;
                vld_d = vld_q;
                if (adv) begin
                    dat_d = {dat_q[gi*DATA_WIDTH-1:0], head_dat};
                    vld_d = {vld_q[gi-1:0], accept};
                end
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                dat_q <= '0;
                vld_q <= '0;
            end else begin
                dat_q <= dat_d;
                vld_q <= vld_d;
            end
        end

        assign out_valid[gi] = vld_q[gi];
        assign out_data[gi*DATA_WIDTH +: DATA_WIDTH] =
            vld_q[gi] ? dat_q[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
    end

`ifdef INPUT_SKEW_B_STALL_CNT_EN
    // ------------------------------------------------------------------
    // Stall cycle counter. A new tile can only start on an advancing cycle,
    // so clearing on the first accept never drops a stall cycle.
    // ------------------------------------------------------------------
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q == IDLE) && accept) begin
            stall_cnt_d = '0;
        end else if (array_stall && busy && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_input_skew_b.sv
// -----------------------------------------------------------------------------
// tb_input_skew_b
//
// Directed bench for input_skew_b with COLS=4, DATA_WIDTH=16, K_DEPTH=4.
// Every accepted row pushes one entry per lane into that lane's queue. Each
// entry holds the advancing-cycle index at which the word must appear. Each
// cycle, the lane outputs are compared with the queue heads.
// -----------------------------------------------------------------------------
module tb_input_skew_b;

    localparam int COLS = 4;
    localparam int DW   = 16;
    localparam int KD   = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic [COLS*DW-1:0]   in_data;
    logic                 in_last;
    logic                 array_stall;
    logic [COLS*DW-1:0]   out_data;
    logic [COLS-1:0]      out_valid;
    logic                 busy;
    logic                 tile_done;
    logic                 len_err;
`ifdef INPUT_SKEW_B_STALL_CNT_EN
    logic [31:0]          stall_cycles;
`endif

    input_skew_b #(
        .COLS       (COLS),
        .DATA_WIDTH (DW),
        .K_DEPTH    (KD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .array_stall (array_stall),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .busy        (busy),
        .tile_done   (tile_done),
        .len_err     (len_err)
`ifdef INPUT_SKEW_B_STALL_CNT_EN
        ,
        .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] d;
        logic [31:0] due;
    } ent_t;

    ent_t sbq [COLS][$];

    int   total = 0;
    int   bad   = 0;
    int   adv_cnt = 0;
    int   cyc;
    int   td_first, td_last, td_count;
    int   le_first, le_count;
    int   l3_first;
    int   acc_cyc;
    bit   acc_flag;
    logic ir_hist [64];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every lane with the head of its scoreboard queue.
    task automatic check_lanes();
        logic        exp_v;
        logic [15:0] exp_d;
        for (int j = 0; j < COLS; j++) begin
            exp_v = 1'b0;
            exp_d = 16'h0;
            if (sbq[j].size() > 0 && sbq[j][0].due == 32'(adv_cnt)) begin
                exp_v = 1'b1;
                exp_d = sbq[j][0].d;
            end
            chk($sformatf("c%0d_lane%0d_valid", cyc, j), 64'(out_valid[j]), 64'(exp_v));
            chk($sformatf("c%0d_lane%0d_data", cyc, j), 64'(out_data[j*DW +: DW]), 64'(exp_d));
        end
    endtask

    // One clock cycle. The inputs for cycle 'cyc' have already been driven.
    task automatic tick();
        logic acc;
        logic adv;
        #1;
        acc = in_valid && in_ready;
        adv = !array_stall;
        if (cyc < 64) ir_hist[cyc] = in_ready;
        if (tile_done === 1'b1) begin
            if (td_count == 0) td_first = cyc;
            td_last = cyc;
            td_count++;
        end
        if (len_err === 1'b1) begin
            if (le_count == 0) le_first = cyc;
            le_count++;
        end
        if (out_valid[3] === 1'b1 && l3_first < 0) l3_first = cyc;
        check_lanes();
        @(posedge clk);
        if (adv) begin
            for (int j = 0; j < COLS; j++) begin
                while (sbq[j].size() > 0 && sbq[j][0].due <= 32'(adv_cnt))
                    void'(sbq[j].pop_front());
            end
            adv_cnt++;
        end
        if (acc) begin
            for (int j = 0; j < COLS; j++)
                sbq[j].push_back({in_data[j*DW +: DW], 32'(adv_cnt + j)});
            acc_flag = 1'b1;
            acc_cyc  = cyc;
        end
        cyc++;
        #1;
    endtask

    task automatic drive(input bit v, input int r, input bit last);
        in_valid = v;
        in_last  = last;
        for (int j = 0; j < COLS; j++)
            in_data[j*DW +: DW] = v ? 16'((r << 8) | j) : 16'h0;
    endtask

    // Offer a row and hold it until it is accepted (bounded).
    task automatic send_row(input int r, input bit last);
        drive(1'b1, r, last);
        acc_flag = 1'b0;
        for (int k = 0; k < 50 && !acc_flag; k++) tick();
        if (!acc_flag) chk("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic idle(input int n);
        drive(1'b0, 0, 1'b0);
        repeat (n) tick();
    endtask

    task automatic start_test();
        cyc      = 0;
        td_count = 0;
        td_first = -1;
        td_last  = -1;
        le_count = 0;
        le_first = -1;
        l3_first = -1;
        for (int i = 0; i < 64; i++) ir_hist[i] = 1'bx;
    endtask

    task automatic send_tile();
        send_row(0, 1'b0);
        send_row(1, 1'b0);
        send_row(2, 1'b0);
        send_row(3, 1'b1);
    endtask

    initial begin
        int b0;
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_last     = 1'b0;
        in_data     = '0;
        array_stall = 1'b0;
        start_test();
        repeat (2) @(posedge clk);
        #1;
        // ---- reset state ----
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_tile_done", 64'(tile_done), 64'd0);
        chk("rst_len_err", 64'(len_err), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
`ifdef INPUT_SKEW_B_STALL_CNT_EN
        chk("rst_stall_cycles", 64'(stall_cycles), 64'd0);
`endif
        rst = 1'b0;

        // ---- skew check ----
        start_test();
        send_tile();
        idle(8);
        chk("skew_td_cycle", 64'(td_first), 64'd8);
        chk("skew_td_count", 64'(td_count), 64'd1);
        chk("skew_len_err_count", 64'(le_count), 64'd0);
        chk("skew_lane3_first", 64'(l3_first), 64'd4);
        chk("skew_ready_drain", 64'(ir_hist[4]), 64'd0);
        chk("skew_ready_done", 64'(ir_hist[8]), 64'd0);
        chk("skew_ready_after", 64'(ir_hist[9]), 64'd1);

        // ---- stall freeze: stall during cycles 2..4 ----
        start_test();
        send_row(0, 1'b0);
        send_row(1, 1'b0);
        drive(1'b1, 2, 1'b0);
        array_stall = 1'b1;
        repeat (3) tick();
        array_stall = 1'b0;
        send_row(2, 1'b0);
        send_row(3, 1'b1);
        idle(10);
        chk("stall_ready_c2", 64'(ir_hist[2]), 64'd0);
        chk("stall_ready_c4", 64'(ir_hist[4]), 64'd0);
        chk("stall_ready_c5", 64'(ir_hist[5]), 64'd1);
        chk("stall_td_cycle", 64'(td_first), 64'd11);
        chk("stall_lane3_first", 64'(l3_first), 64'd7);

        // ---- bubbles between R1 and R2 ----
        start_test();
        send_row(0, 1'b0);
        send_row(1, 1'b0);
        idle(2);
        send_row(2, 1'b0);
        send_row(3, 1'b1);
        idle(8);
        chk("bubble_td_cycle", 64'(td_first), 64'd10);
        chk("bubble_len_err_count", 64'(le_count), 64'd0);

        // ---- short tile: in_last on row 2 ----
        start_test();
        send_row(0, 1'b0);
        send_row(1, 1'b1);
        idle(8);
        chk("short_le_cycle", 64'(le_first), 64'd2);
        chk("short_le_count", 64'(le_count), 64'd1);
        chk("short_td_cycle", 64'(td_first), 64'd6);
        chk("short_ready_drain", 64'(ir_hist[5]), 64'd0);
        chk("short_ready_after", 64'(ir_hist[7]), 64'd1);

        // ---- long tile: no in_last after K_DEPTH rows ----
        start_test();
        send_row(0, 1'b0);
        send_row(1, 1'b0);
        send_row(2, 1'b0);
        send_row(3, 1'b0);
        drive(1'b1, 4, 1'b0);
        acc_flag = 1'b0;
        repeat (4) tick();
        chk("long_no_accept_in_drain", 64'(acc_flag), 64'd0);
        idle(6);
        chk("long_le_cycle", 64'(le_first), 64'd4);
        chk("long_le_count", 64'(le_count), 64'd1);
        chk("long_ready_drop", 64'(ir_hist[4]), 64'd0);
        chk("long_td_cycle", 64'(td_first), 64'd8);

        // ---- reset mid-tile ----
        start_test();
        send_row(0, 1'b0);
        send_row(1, 1'b0);
        drive(1'b0, 0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_tile_done", 64'(tile_done), 64'd0);
        for (int j = 0; j < COLS; j++) sbq[j].delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        start_test();
        idle(6);
        chk("midrst_no_td", 64'(td_count), 64'd0);
        chk("midrst_idle_busy", 64'(busy), 64'd0);
        start_test();
        send_tile();
        idle(8);
        chk("postrst_td_cycle", 64'(td_first), 64'd8);

        // ---- back-to-back tiles ----
        start_test();
        send_tile();
        send_row(0, 1'b0);
        b0 = acc_cyc;
        send_row(1, 1'b0);
        send_row(2, 1'b0);
        send_row(3, 1'b1);
        idle(10);
        chk("b2b_second_accept", 64'(b0), 64'd9);
        chk("b2b_td_count", 64'(td_count), 64'd2);
        chk("b2b_td_first", 64'(td_first), 64'd8);
        chk("b2b_td_last", 64'(td_last), 64'd17);

        // ---- stall during drain: 5 stall cycles while busy ----
        start_test();
        send_tile();
        idle(1);
        array_stall = 1'b1;
        repeat (5) tick();
        array_stall = 1'b0;
        idle(6);
        chk("dstall_td_cycle", 64'(td_first), 64'd13);
        chk("dstall_td_count", 64'(td_count), 64'd1);
`ifdef INPUT_SKEW_B_STALL_CNT_EN
        chk("stallcnt_after_done", 64'(stall_cycles), 64'd5);
`endif
        start_test();
        send_row(0, 1'b0);
`ifdef INPUT_SKEW_B_STALL_CNT_EN
        chk("stallcnt_cleared", 64'(stall_cycles), 64'd0);
`endif
        send_row(1, 1'b0);
        send_row(2, 1'b0);
        send_row(3, 1'b1);
        idle(8);
        chk("final_td_cycle", 64'(td_first), 64'd8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
